// File: rtl/deintretesator_regula.sv
// Receive-side byte de-interleaver: undoes the adjacent-bit swaps of the turbo-path
// interleaver one per cycle. Define DEINT_LFSR_LOCAL_EN to source the pattern from a local LFSR.
module deintretesator_regula #(
    parameter logic [7:0] SEED = 8'hAA
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] Data_In,
    input  logic [7:0] Pattern_In,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] Data_Out,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SWAP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_reg,    state_next;
    logic [2:0] step_reg,     step_next;
    logic [7:0] work_reg,     work_next;
    logic [7:0] pattern_reg,  pattern_next;
    logic [7:0] data_out_reg, data_out_next;
    logic [7:0] pattern_src;

    function automatic logic [7:0] swap_pair(input logic [7:0] v, input int hi, input int lo);
        logic [7:0] r;
        r     = v;
        r[hi] = v[lo];
        r[lo] = v[hi];
        return r;
    endfunction

`ifdef DEINT_LFSR_LOCAL_EN
    logic [7:0] lfsr_reg;
    logic       unused_pattern;

    // Free-running x^8+x^4+x^3+x^2+1, shifting right; must stay phase-locked to the transmitter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= SEED;
        end else begin
            lfsr_reg <= {lfsr_reg[4] ^ lfsr_reg[3] ^ lfsr_reg[2] ^ lfsr_reg[0], lfsr_reg[7:1]};
        end
    end

    assign pattern_src    = lfsr_reg;
    assign unused_pattern = ^Pattern_In;
`else
    logic unused_seed;

    assign pattern_src = Pattern_In;
    assign unused_seed = ^SEED;
`endif

    // Candidate result of every step's swap; step 0 wraps bit 0 with bit 7.
    logic [7:0][7:0] step_swap;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_step
            localparam int HI = (gi == 0) ? 7 : gi;
            localparam int LO = (gi == 0) ? 0 : gi - 1;
            assign step_swap[gi] = swap_pair(work_reg, HI, LO);
        end
    endgenerate

    logic [7:0] swap_stage;
    assign swap_stage = pattern_reg[step_reg] ? step_swap[step_reg] : work_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            step_reg     <= 3'd0;
            work_reg     <= 8'h00;
            pattern_reg  <= 8'h00;
            data_out_reg <= 8'h00;
        end else begin
            state_reg    <= state_next;
            step_reg     <= step_next;
            work_reg     <= work_next;
            pattern_reg  <= pattern_next;
            data_out_reg <= data_out_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        step_next     = step_reg;
        work_next     = work_reg;
        pattern_next  = pattern_reg;
        data_out_next = data_out_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    work_next    = Data_In;
                    pattern_next = pattern_src;
                    step_next    = 3'd0;
                    state_next   = SWAP;
                end
            end
            SWAP: begin
                work_next = swap_stage;
                step_next = step_reg + 3'd1;
                if (step_reg == 3'd7) begin
                    data_out_next = swap_stage;
                    state_next    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign Data_Out  = data_out_reg;

endmodule

// File: tb/tb_deintretesator_regula.sv
// Self-checking bench for deintretesator_regula: directed words, full round trip
// through an interleaver model, backpressure and mid-word reset.
module tb_deintretesator_regula;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] Data_In = 8'h00;
    logic [7:0] Pattern_In = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] Data_Out;
    logic       out_valid;
    logic       out_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    deintretesator_regula #(.SEED(8'hAA)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .Data_In    (Data_In),
        .Pattern_In (Pattern_In),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .Data_Out   (Data_Out),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] swp(input logic [7:0] v, input int a, input int b);
        logic [7:0] r;
        r    = v;
        r[a] = v[b];
        r[b] = v[a];
        return r;
    endfunction

    // Transmit side: pairs 7/6 down to 1/0, then 0/7.
    function automatic logic [7:0] interleave_model(input logic [7:0] d, input logic [7:0] p);
        logic [7:0] r;
        r = d;
        for (int k = 7; k >= 1; k--)
            if (p[k]) r = swp(r, k, k - 1);
        if (p[0]) r = swp(r, 0, 7);
        return r;
    endfunction

    // Receive side: exactly the reverse sequence.
    function automatic logic [7:0] deint_model(input logic [7:0] d, input logic [7:0] p);
        logic [7:0] r;
        r = d;
        if (p[0]) r = swp(r, 0, 7);
        for (int k = 1; k <= 7; k++)
            if (p[k]) r = swp(r, k, k - 1);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Cycle model: m_cnt counts edges since accept (0 = idle, 9 = result held).
    int         m_cnt = 0;
    logic [7:0] m_pending = 8'h00;
    logic [7:0] m_out = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cnt <= 0;
            m_out <= 8'h00;
        end else if (m_cnt == 0) begin
            if (in_valid) begin
                m_pending <= deint_model(Data_In, Pattern_In);
                m_cnt     <= 1;
            end
        end else if (m_cnt < 8) begin
            m_cnt <= m_cnt + 1;
        end else if (m_cnt == 8) begin
            m_cnt <= 9;
            m_out <= m_pending;
        end else if (out_ready) begin
            m_cnt <= 0;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_in_ready", 32'(in_ready), 32'd1);
            check("rst_out_valid", 32'(out_valid), 32'd0);
            check("rst_data_out", 32'(Data_Out), 32'h00);
        end else begin
            check("cyc_in_ready", 32'(in_ready), 32'(m_cnt == 0));
            check("cyc_out_valid", 32'(out_valid), 32'(m_cnt == 9));
            check("cyc_data_out", 32'(Data_Out), 32'(m_out));
        end
    end

    task automatic run_word(input logic [7:0] d, input logic [7:0] p, input logic [7:0] exp,
                            input string name, input int hold, input bit verbose);
        int         w;
        int         lat;
        logic [7:0] held;
        w = 0;
        while (!in_ready && w < 30) begin
            @(negedge clk);
            w++;
        end
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        Data_In    = d;
        Pattern_In = p;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid   = 1'b0;
        Data_In    = 8'($urandom);
        Pattern_In = 8'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 32'(lat), 32'd8);
        check({name, "_data"}, 32'(Data_Out), 32'(exp));
        held = Data_Out;
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 4 == 1);
            Data_In  = 8'($urandom);
            @(negedge clk);
            check({name, "_hold_data"}, 32'(Data_Out), 32'(held));
            check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({name, "_hold_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({name, "_idle"}, 32'(in_ready), 32'd1);
        if (verbose)
            $display("[TB] %s: in=%02h pat=%02h out=%02h exp=%02h lat=%0d", name, d, p, Data_Out, exp, lat);
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog: got no finish expected finish before 3ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] orig;
        int         rt_fail_before;
        bit         rose;

        // Pin the model against hand-worked values.
        check("pin_deint_01", 32'(deint_model(8'h80, 8'h01)), 32'h01);
        check("pin_deint_80", 32'(deint_model(8'h40, 8'h80)), 32'h80);
        check("pin_deint_ff", 32'(deint_model(8'h01, 8'hFF)), 32'h40);
        check("pin_inter_ff", 32'(interleave_model(8'h40, 8'hFF)), 32'h01);

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        run_word(8'hA5, 8'h00, 8'hA5, "pat00", 0, 1'b1);
        run_word(8'h80, 8'h01, 8'h01, "pat01", 0, 1'b1);
        run_word(8'h40, 8'h80, 8'h80, "pat80", 0, 1'b1);
        run_word(8'h01, 8'hFF, 8'h40, "patff", 0, 1'b1);
        run_word(8'h3C, 8'h5A, deint_model(8'h3C, 8'h5A), "backpressure", 20, 1'b1);

        // Abort a word at step 4 with an asynchronous reset.
        Data_In    = 8'h0F;
        Pattern_In = 8'hC3;
        in_valid   = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        rose = 1'b0;
        repeat (4) begin
            @(negedge clk);
            rose |= out_valid;
        end
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_data_out", 32'(Data_Out), 32'h00);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            rose |= out_valid;
        end
        check("abort_never_valid", 32'(rose), 32'd0);
        $display("[TB] abort: word 0F/C3 dropped by reset at step 4");
        run_word(8'h96, 8'h3B, deint_model(8'h96, 8'h3B), "after_reset", 0, 1'b1);

        for (int p = 0; p < 256; p++) begin
            rt_fail_before = n_fail;
            for (int j = 0; j < 16; j++) begin
                orig = 8'($urandom);
                run_word(interleave_model(orig, 8'(p)), 8'(p), orig, "roundtrip", 0, 1'b0);
            end
            $display("[TB] roundtrip pat=%02h: 16 words, %0d new failures", p, n_fail - rt_fail_before);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
